// File: rtl/timing_ring_ctrl.sv
// rtl/timing_ring_ctrl.sv - one-hot memory-cycle timing ring sequenced from the oscillator card
// Optional oscillator-loss watchdog is built when TIMING_RING_OSC_WATCHDOG_EN is defined.
module timing_ring_ctrl #(
    parameter int RING_LEN       = 10,
    parameter int PULSES_PER_POS = 2,
    parameter int WDT_CLKS       = 400
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                osc,
    input  logic                run_req,
    input  logic                step_req,
    input  logic                stop_req,
    output logic [RING_LEN-1:0] ring,
    output logic                cycle_start,
    output logic                cycle_end,
    output logic                running,
    output logic                osc_fault
);

    localparam int POS_W = $clog2(RING_LEN);
    localparam int SUB_W = (PULSES_PER_POS > 1) ? $clog2(PULSES_PER_POS) : 1;
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(RING_LEN - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(PULSES_PER_POS - 1);

    if (RING_LEN < 2 || PULSES_PER_POS < 1 || WDT_CLKS < 2) begin : g_param_check
        $error("timing_ring_ctrl: illegal parameter value");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [POS_W-1:0] pos, pos_n;
    logic [SUB_W-1:0] sub, sub_n;
    logic             start_pend, start_pend_n;
    logic             mode_run, mode_run_n;
    logic             stop_pend, stop_pend_n;
    logic             cycle_start_n, cycle_end_n;
    logic             s1, s2, s3;
    logic             tick;
    logic             wdt_hit;
    logic             start_block;

    // Two-flop synchroniser plus an edge flop; one tick per oscillator rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= osc;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

`ifdef TIMING_RING_OSC_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CLKS);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CLKS - 1);

    logic [WDT_W-1:0] wdt_cnt;
    logic             fault_q;

    // Saturates one short of the limit; the hit fires on the edge that would reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt <= '0;
        end else if (tick) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt != WDT_LAST) begin
            wdt_cnt <= wdt_cnt + WDT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (wdt_hit) begin
            fault_q <= 1'b1;
        end
    end

    assign wdt_hit     = (state != IDLE) && !tick && (wdt_cnt == WDT_LAST);
    assign start_block = fault_q;
    assign osc_fault   = fault_q;
`else
    assign wdt_hit     = 1'b0;
    assign start_block = 1'b0;
    assign osc_fault   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pos         <= '0;
            sub         <= '0;
            start_pend  <= 1'b0;
            mode_run    <= 1'b0;
            stop_pend   <= 1'b0;
            cycle_start <= 1'b0;
            cycle_end   <= 1'b0;
        end else begin
            state       <= state_n;
            pos         <= pos_n;
            sub         <= sub_n;
            start_pend  <= start_pend_n;
            mode_run    <= mode_run_n;
            stop_pend   <= stop_pend_n;
            cycle_start <= cycle_start_n;
            cycle_end   <= cycle_end_n;
        end
    end

    always_comb begin
        state_n       = state;
        pos_n         = pos;
        sub_n         = sub;
        start_pend_n  = start_pend;
        mode_run_n    = mode_run;
        stop_pend_n   = stop_pend;
        cycle_start_n = 1'b0;
        cycle_end_n   = 1'b0;

        unique case (state)
            IDLE: begin
                pos_n       = '0;
                sub_n       = '0;
                stop_pend_n = 1'b0;
                if (!start_block) begin
                    // A run request overrides a pending step; the same tick may start it.
                    if (run_req) begin
                        start_pend_n = 1'b1;
                        mode_run_n   = 1'b1;
                    end else if (step_req && !start_pend) begin
                        start_pend_n = 1'b1;
                        mode_run_n   = 1'b0;
                    end
                    if (tick && start_pend_n) begin
                        state_n       = mode_run_n ? RUN : STEP;
                        start_pend_n  = 1'b0;
                        cycle_start_n = 1'b1;
                    end
                end
            end
            default: begin
                if (state == RUN && stop_req) begin
                    stop_pend_n = 1'b1;
                end
                if (tick) begin
                    if (sub != SUB_LAST) begin
                        sub_n = sub + SUB_W'(1);
                    end else begin
                        sub_n = '0;
                        if (pos != POS_LAST) begin
                            pos_n = pos + POS_W'(1);
                        end else begin
                            // Run level and stop are judged only here, so cycles are never cut short.
                            pos_n       = '0;
                            cycle_end_n = 1'b1;
                            if (state == RUN && run_req && !stop_pend_n) begin
                                cycle_start_n = 1'b1;
                            end else begin
                                state_n     = IDLE;
                                stop_pend_n = 1'b0;
                            end
                        end
                    end
                end
            end
        endcase

        if (wdt_hit) begin
            state_n       = IDLE;
            pos_n         = '0;
            sub_n         = '0;
            start_pend_n  = 1'b0;
            stop_pend_n   = 1'b0;
            cycle_start_n = 1'b0;
            cycle_end_n   = 1'b0;
        end
    end

    always_comb begin
        ring = '0;
        if (state != IDLE) begin
            ring = RING_LEN'(1) << pos;
        end
    end

    assign running = (state != IDLE);

endmodule

// File: tb/tb_timing_ring_ctrl.sv
// tb/tb_timing_ring_ctrl.sv - scoreboard bench for timing_ring_ctrl
module tb_timing_ring_ctrl;

    localparam int RL  = 10;
    localparam int PP  = 2;
    localparam int WD  = 400;
    localparam int POS_CLKS = PP * 100;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          osc      = 1'b0;
    logic          run_req  = 1'b0;
    logic          step_req = 1'b0;
    logic          stop_req = 1'b0;
    logic [RL-1:0] ring;
    logic          cycle_start;
    logic          cycle_end;
    logic          running;
    logic          osc_fault;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int last_evt = 0;
    int ph       = 0;
    bit osc_en   = 1'b1;

    typedef struct {
        logic [RL-1:0] ring;
        logic          cs;
        logic          ce;
        int            dur;
    } evt_t;

    evt_t          exp_q[$];
    logic [RL-1:0] prev_ring = '0;

    timing_ring_ctrl #(
        .RING_LEN      (RL),
        .PULSES_PER_POS(PP),
        .WDT_CLKS      (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .osc        (osc),
        .run_req    (run_req),
        .step_req   (step_req),
        .stop_req   (stop_req),
        .ring       (ring),
        .cycle_start(cycle_start),
        .cycle_end  (cycle_end),
        .running    (running),
        .osc_fault  (osc_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Oscillator: 100 clk period, edges placed off the clk edge.
    always begin
        @(posedge clk);
        #2;
        if (!osc_en) begin
            osc = 1'b0;
            ph  = 0;
        end else begin
            ph = ph + 1;
            if (ph == 50) begin
                osc = ~osc;
                ph  = 0;
            end
        end
    end

    // Every ring change or pulse must match the next expected event.
    always @(negedge clk) begin
        if (ring !== prev_ring || cycle_start !== 1'b0 || cycle_end !== 1'b0) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_event: ring=%b cs=%b ce=%b at cyc %0d, required no event",
                         ring, cycle_start, cycle_end, cyc);
            end else begin
                evt_t e;
                e = exp_q.pop_front();
                if (ring !== e.ring || cycle_start !== e.cs || cycle_end !== e.ce) begin
                    n_errors++;
                    $display("FAIL event: ring=%b cs=%b ce=%b, required ring=%b cs=%b ce=%b",
                             ring, cycle_start, cycle_end, e.ring, e.cs, e.ce);
                end
                if (e.dur >= 0) begin
                    n_checks++;
                    if (cyc - last_evt != e.dur) begin
                        n_errors++;
                        $display("FAIL event_spacing: ring=%b after %0d clk, required %0d clk",
                                 ring, cyc - last_evt, e.dur);
                    end
                end
            end
            last_evt = cyc;
        end
        prev_ring = ring;
    end

    task automatic push_evt(input logic [RL-1:0] r, input logic cs, input logic ce, input int dur);
        evt_t e;
        e.ring = r;
        e.cs   = cs;
        e.ce   = ce;
        e.dur  = dur;
        exp_q.push_back(e);
    endtask

    task automatic push_cycle(input bit wrap_in, input bit wrap_out);
        logic [RL-1:0] r;
        r = RL'(1);
        push_evt(r, 1'b1, wrap_in, wrap_in ? POS_CLKS : -1);
        for (int i = 1; i < RL; i++) begin
            r = r << 1;
            push_evt(r, 1'b0, 1'b0, POS_CLKS);
        end
        if (!wrap_out) push_evt('0, 1'b0, 1'b1, POS_CLKS);
    endtask

    task automatic wait_q(input int n, input string name);
        int budget;
        budget = 6000;
        do begin
            @(negedge clk);
            #1;
            budget--;
        end while (exp_q.size() > n && budget > 0);
        if (exp_q.size() > n) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_timeout: pending=%0d, required <=%0d", name, exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic pulse(input int which);
        @(negedge clk);
        #1;
        if (which == 0) step_req = 1'b1; else stop_req = 1'b1;
        @(negedge clk);
        #1;
        step_req = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 5;
        if (ring !== '0) begin n_errors++; $display("FAIL reset_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL reset_running: %b, required 0", running); end
        if (cycle_start !== 1'b0) begin n_errors++; $display("FAIL reset_cs: %b, required 0", cycle_start); end
        if (cycle_end !== 1'b0) begin n_errors++; $display("FAIL reset_ce: %b, required 0", cycle_end); end
        if (osc_fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault: %b, required 0", osc_fault); end
        #1 rst = 1'b0;
        repeat (300) @(negedge clk);
        n_checks += 2;
        if (ring !== '0) begin n_errors++; $display("FAIL idle_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL idle_running: %b, required 0", running); end
    endtask

    task automatic test_single_step();
        push_cycle(1'b0, 1'b0);
        pulse(0);
        wait_q(0, "step");
        repeat (250) @(negedge clk);
        n_checks += 2;
        if (ring !== '0) begin n_errors++; $display("FAIL step_end_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL step_end_running: %b, required 0", running); end
    endtask

    task automatic test_continuous_run();
        push_cycle(1'b0, 1'b1);
        push_cycle(1'b1, 1'b1);
        push_cycle(1'b1, 1'b0);
        #1 run_req = 1'b1;
        wait_q(RL, "run_third_cycle");
        run_req = 1'b0;
        wait_q(0, "run");
        repeat (250) @(negedge clk);
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL run_end_running: %b, required 0", running); end
    endtask

    task automatic test_stop_mid_cycle();
        push_cycle(1'b0, 1'b0);
        #1 run_req = 1'b1;
        wait_q(RL - 4, "stop_pos4");
        pulse(1);
        wait_q(0, "stop");
        run_req = 1'b0;
        repeat (250) @(negedge clk);
        n_checks += 2;
        if (ring !== '0) begin n_errors++; $display("FAIL stop_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL stop_running: %b, required 0", running); end
    endtask

    task automatic test_run_drop();
        push_cycle(1'b0, 1'b0);
        #1 run_req = 1'b1;
        wait_q(RL - 3, "drop_pos3");
        run_req = 1'b0;
        wait_q(0, "drop");
        repeat (250) @(negedge clk);
        n_checks++;
        if (running !== 1'b0) begin n_errors++; $display("FAIL drop_running: %b, required 0", running); end
    endtask

    task automatic test_reset_mid_cycle();
        logic [RL-1:0] r;
        r = RL'(1);
        push_evt(r, 1'b1, 1'b0, -1);
        for (int i = 1; i <= 6; i++) begin
            r = r << 1;
            push_evt(r, 1'b0, 1'b0, POS_CLKS);
        end
        push_evt('0, 1'b0, 1'b0, -1);
        pulse(0);
        wait_q(1, "reset_pos6");
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        n_checks += 2;
        if (ring !== '0) begin n_errors++; $display("FAIL midreset_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL midreset_running: %b, required 0", running); end
        repeat (10) @(negedge clk);
        push_cycle(1'b0, 1'b0);
        pulse(0);
        wait_q(0, "restep");
    endtask

`ifdef TIMING_RING_OSC_WATCHDOG_EN
    task automatic test_watchdog();
        int n;
        push_evt(RL'(1), 1'b1, 1'b0, -1);
        #1 run_req = 1'b1;
        wait_q(0, "wdt_start");
        osc_en = 1'b0;
        push_evt('0, 1'b0, 1'b0, -1);
        n = 0;
        while (osc_fault !== 1'b1 && n < 600) begin
            @(negedge clk);
            n++;
        end
        n_checks += 2;
        if (n != WD) begin n_errors++; $display("FAIL wdt_latency: %0d clk, required %0d", n, WD); end
        if (ring !== '0) begin n_errors++; $display("FAIL wdt_ring: %b, required 0", ring); end
        run_req = 1'b0;
        osc_en  = 1'b1;
        pulse(0);
        repeat (400) @(negedge clk);
        n_checks += 3;
        if (ring !== '0) begin n_errors++; $display("FAIL wdt_block_ring: %b, required 0", ring); end
        if (running !== 1'b0) begin n_errors++; $display("FAIL wdt_block_running: %b, required 0", running); end
        if (osc_fault !== 1'b1) begin n_errors++; $display("FAIL wdt_sticky: %b, required 1", osc_fault); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_continuous_run();
        test_stop_mid_cycle();
        test_run_drop();
        test_reset_mid_cycle();
`ifdef TIMING_RING_OSC_WATCHDOG_EN
        test_watchdog();
`endif
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL leftover_events: %0d, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
        $fatal(1);
    end

endmodule
